fetch_queue: RTL and testbench
==============================

# fetch_queue

Parametrised fetch stage that replaces the single-register PC/instruction-memory path with a request/response instruction-memory port and a DEPTH-entry prefetch queue. It generates sequential fetch addresses, tracks in-flight requests, buffers returned instructions, and presents them to decode with a valid/ready handshake. Redirects from execute flush the queue and all in-flight responses. Sits between the PC-select logic and the decode stage.

## Interface
- `WIDTH`, 32: instruction and address width in bits.
- `DEPTH`, 4: prefetch queue entries; power of two, ≥2.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `clk` input 1: clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `redirect_valid` input 1: flush and restart fetch at `redirect_pc`.
- `redirect_pc` input WIDTH: new fetch address; bits [1:0] are ignored and treated as 0.
- `imem_req` output 1: fetch request valid.
- `imem_addr` output WIDTH: fetch address; word aligned.
- `imem_ready` input 1: memory accepts the request this cycle.
- `imem_rvalid` input 1: response valid; arrives exactly one cycle after acceptance, in order.
- `imem_rdata` input WIDTH: returned instruction.
- `instr_valid` output 1: queue head valid.
- `instr` output WIDTH: queue head instruction.
- `instr_pc` output WIDTH: address of queue head.
- `instr_ready` input 1: decode consumes the head this cycle.
- `perf_fetched` output 32: instructions enqueued.
- `perf_stall` output 32: cycles with `instr_valid & ~instr_ready`.

## Operation
- Internal fetch PC `fpc` drives `imem_addr`. A request is accepted when `imem_req & imem_ready`; `fpc` then advances by 4, wrapping modulo 2^WIDTH (0xFFFF_FFFC → 0).
- `imem_req` = ~flush_pending & (count + inflight < DEPTH). `inflight` is 0 or 1. While unaccepted, `imem_req`/`imem_addr` hold stable.
- On `imem_rvalid` with no kill pending, {`imem_rdata`, addr} is written at the tail. Each entry stores its own PC.
- Pop when `instr_valid & instr_ready`. Simultaneous push and pop keep count unchanged.
- Redirect cycle: count, head, and tail are cleared. `fpc` ← `{redirect_pc[WIDTH-1:2],2'b00}`. An accepted or in-flight request is marked killed, so its response is dropped. `imem_req` is 0 in the redirect cycle.
- Priority: redirect > response push > pop. A pop in the redirect cycle is discarded.
- Back-to-back redirects: the last one wins, and each one kills the prior in-flight request.
- Full queue: no request is issued. Credit counting guarantees that a response never arrives at a full queue.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=RESET_PC, `instr_valid`=0, `instr`=0, `instr_pc`=0, perf counters=0, queue empty, no inflight.
- Reset assert is asynchronous. It takes effect immediately, even in the middle of a request, and any pending response is dropped after release.
- First cycle after reset release (C0): `imem_req`=1 at RESET_PC. With `imem_ready`=1, response in C1, `instr_valid`=1 in C2.
- Redirect in cycle R: request at `redirect_pc` in R+1, response in R+2, `instr_valid` with `instr_pc`=redirect_pc in R+3.
- Sustained throughput is 1 instr/cycle when `imem_ready` and `instr_ready` are held high, for DEPTH ≥ 2.
- Outputs `instr`, `instr_pc`, and `instr_valid` are driven from registers, with no combinational path from `instr_ready`.

## Configuration
- `FETCH_PERF_CNT_EN` defined: `perf_fetched` increments on every queue push, and `perf_stall` increments every cycle with `instr_valid & ~instr_ready`. Both are 32-bit, wrap on overflow, and are cleared only by reset.
- Not defined: the counters are not instantiated, and both ports are tied to 0.

## Test plan
- Reset release with RESET_PC=0x100, `imem_ready`=1, `instr_ready`=1, rdata=addr^0xA5A5A5A5 -> `instr_pc` = 0x100, 0x104, 0x108… one per cycle, first `instr_valid` in C2.
- `instr_ready`=0 for 10 cycles, DEPTH=4 -> exactly 4 entries queued, `imem_req` drops, head holds 0x100. With the macro on, `perf_stall`=10. On release, the queue drains in order with no gaps or duplicates.
- `imem_ready` low for 3 cycles -> `imem_addr` stable at the same value, `fpc` not advanced, no `instr_valid` bubble beyond the queue's drained entries.
- Redirect to 0x2002 while 3 entries are queued and 1 is in flight -> the next cycle has `instr_valid`=0. The in-flight response is dropped. The first instr after that has `instr_pc`=0x2000 at R+3.
- Redirect with `imem_rvalid` and pop in the same cycle -> nothing enqueued, nothing popped, and `perf_fetched` is not incremented.
- Redirect to 0xFFFF_FFFC -> fetched PCs 0xFFFF_FFFC, 0x0, 0x4. Assert `rst` mid-stream -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: bundles the fetch stage's redirect, instruction-memory,
// decode-side and performance-counter signals.
//
//   redirect_valid / redirect_pc      : flush request from execute
//   imem_req / imem_addr / imem_ready : fetch request channel
//   imem_rvalid / imem_rdata          : fetch response channel (1 cycle after accept)
//   instr_valid / instr / instr_pc    : queue head presented to decode
//   instr_ready                       : decode consumes the head
//   perf_fetched / perf_stall         : performance counters (zero when disabled)
//
// Modports:
//   master : the fetch_queue side (drives requests, head and counters)
//   slave  : the surrounding system (memory, decode, execute)
interface fetch_queue_if #(
  parameter int unsigned WIDTH = 32
);
  logic             redirect_valid;
  logic [WIDTH-1:0] redirect_pc;
  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_ready;
  logic             imem_rvalid;
  logic [WIDTH-1:0] imem_rdata;
  logic             instr_valid;
  logic [WIDTH-1:0] instr;
  logic [WIDTH-1:0] instr_pc;
  logic             instr_ready;
  logic [31:0]      perf_fetched;
  logic [31:0]      perf_stall;

  modport master (
    input  redirect_valid, redirect_pc,
    output imem_req, imem_addr,
    input  imem_ready, imem_rvalid, imem_rdata,
    output instr_valid, instr, instr_pc,
    input  instr_ready,
    output perf_fetched, perf_stall
  );

  modport slave (
    output redirect_valid, redirect_pc,
    input  imem_req, imem_addr,
    output imem_ready, imem_rvalid, imem_rdata,
    input  instr_valid, instr, instr_pc,
    output instr_ready,
    input  perf_fetched, perf_stall
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: sequential instruction fetch with a DEPTH-entry prefetch queue.
// Generates word-aligned fetch addresses, keeps at most one request in flight,
// buffers {instruction, pc} pairs and presents the head to decode. A redirect
// flushes the queue and drops any response belonging to the old stream.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active low
//   bus  : fetch_queue_if.master (redirect, imem request/response, decode
//          handshake, performance counters)
//
// Parameters: WIDTH (address/instruction width), DEPTH (power of two, >= 2),
//             RESET_PC (first fetch address).
//
// Build option: define FETCH_PERF_CNT_EN to instantiate the 32-bit
// perf_fetched / perf_stall counters; otherwise both read as zero.
module fetch_queue #(
  parameter int unsigned      WIDTH    = 32,
  parameter int unsigned      DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  fetch_queue_if.master bus
);

  localparam int unsigned      PTR_W      = $clog2(DEPTH);
  localparam int unsigned      CNT_W      = PTR_W + 1;
  localparam logic [WIDTH-1:0] ALIGN_MASK = {{(WIDTH-2){1'b1}}, 2'b00};
  localparam logic [WIDTH-1:0] PC_STEP    = WIDTH'(4);

  logic [WIDTH-1:0] fpc_q, fpc_d;
  logic             inflight_q, inflight_d;
  logic [WIDTH-1:0] inflight_pc_q, inflight_pc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] entry_instr_q [DEPTH];
  logic [WIDTH-1:0] entry_instr_d [DEPTH];
  logic [WIDTH-1:0] entry_pc_q    [DEPTH];
  logic [WIDTH-1:0] entry_pc_d    [DEPTH];

  logic req;
  logic accept;
  logic push;
  logic pop;

  // Handshake decisions. The request is gated by rst so that imem_req reads 0
  // for the whole reset interval and rises in the first cycle after release.
  // A response is only accepted if this block actually has one outstanding;
  // that drops responses to requests issued before a reset or redirect.
  always_comb begin
    req    = rst & ~bus.redirect_valid &
             (({1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q}) < (CNT_W+1)'(DEPTH));
    accept = req & bus.imem_ready;
    push   = bus.imem_rvalid & inflight_q & ~bus.redirect_valid;
    pop    = valid_q & bus.instr_ready & ~bus.redirect_valid;
  end

  always_comb begin
    fpc_d         = fpc_q;
    inflight_d    = accept;
    inflight_pc_d = inflight_pc_q;
    count_d       = count_q;
    head_d        = head_q;
    tail_d        = tail_q;
    entry_instr_d = entry_instr_q;
    entry_pc_d    = entry_pc_q;

    if (accept) begin
      fpc_d         = fpc_q + PC_STEP;
      inflight_pc_d = fpc_q;
    end

    if (bus.redirect_valid) begin
      fpc_d   = bus.redirect_pc & ALIGN_MASK;
      count_d = '0;
      head_d  = '0;
      tail_d  = '0;
    end else begin
      if (push) begin
        entry_instr_d[tail_q] = bus.imem_rdata;
        entry_pc_d[tail_q]    = inflight_pc_q;
        tail_d                = tail_q + PTR_W'(1);
      end
      if (pop) begin
        head_d = head_q + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end

    // Head valid is registered so decode sees no path from instr_ready.
    valid_d = (count_d != '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fpc_q         <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      count_q       <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      valid_q       <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        entry_instr_q[i] <= '0;
        entry_pc_q[i]    <= '0;
      end
    end else begin
      fpc_q         <= fpc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      count_q       <= count_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      valid_q       <= valid_d;
      entry_instr_q <= entry_instr_d;
      entry_pc_q    <= entry_pc_d;
    end
  end

  assign bus.imem_req    = req;
  assign bus.imem_addr   = fpc_q;
  assign bus.instr_valid = valid_q;
  assign bus.instr       = entry_instr_q[head_q];
  assign bus.instr_pc    = entry_pc_q[head_q];

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_stall_d   = perf_stall_q;
    if (push) begin
      perf_fetched_d = perf_fetched_q + 32'd1;
    end
    if (valid_q & ~bus.instr_ready) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign bus.perf_fetched = perf_fetched_q;
  assign bus.perf_stall   = perf_stall_q;
`else
  assign bus.perf_fetched = '0;
  assign bus.perf_stall   = '0;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: drives fetch_queue through directed scenarios (reset start,
// decode stall, memory stall, redirect under load, address wrap, mid-stream
// reset) followed by randomized traffic, comparing every cycle against a
// queue-based reference model of the fetch stage.
module tb_fetch_queue;
  localparam int unsigned WIDTH    = 32;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0100;
  localparam logic [31:0] K        = 32'hA5A5_A5A5;
`ifdef FETCH_PERF_CNT_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fetch_queue_if #(.WIDTH(WIDTH)) bus_if ();

  fetch_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: queue of PCs held by the prefetch buffer, fetch PC,
  // one possible outstanding response, performance totals.
  logic [31:0] mq[$];
  logic [31:0] m_fpc;
  logic [31:0] m_resp_pc;
  bit          m_resp;
  logic [31:0] m_fetched;
  logic [31:0] m_stall;

  // Memory side: response owed next cycle for an accepted request.
  bit          mem_pend;
  logic [31:0] mem_pend_addr;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_fpc     = RESET_PC;
    m_resp    = 1'b0;
    m_resp_pc = '0;
    m_fetched = '0;
    m_stall   = '0;
  endtask

  // Called at a negedge. Asserts reset off-edge, checks the immediate reset
  // values, then releases at the next negedge. stale_rsp makes the memory
  // return a response in the first cycle after release that must be ignored.
  task automatic do_reset(input bit stale_rsp);
    #2 rst = 1'b0;
    #1;
    check_eq("rst_imem_req", bus_if.imem_req, 32'd0);
    check_eq("rst_imem_addr", bus_if.imem_addr, RESET_PC);
    check_eq("rst_instr_valid", bus_if.instr_valid, 32'd0);
    check_eq("rst_instr", bus_if.instr, 32'd0);
    check_eq("rst_instr_pc", bus_if.instr_pc, 32'd0);
    check_eq("rst_perf_fetched", bus_if.perf_fetched, 32'd0);
    check_eq("rst_perf_stall", bus_if.perf_stall, 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst           = 1'b1;
    mem_pend      = stale_rsp;
    mem_pend_addr = 32'hDEAD_BEE0;
  endtask

  // One clock cycle, entered and left at a negedge.
  task automatic step(input bit rd, input logic [31:0] rpc, input bit mrdy, input bit drdy);
    bit          exp_req;
    bit          head_v;
    bit          acc_dut;
    logic [31:0] addr_dut;
    bus_if.redirect_valid = rd;
    bus_if.redirect_pc    = rpc;
    bus_if.imem_ready     = mrdy;
    bus_if.instr_ready    = drdy;
    bus_if.imem_rvalid    = mem_pend;
    bus_if.imem_rdata     = mem_pend_addr ^ K;
    #1;
    head_v  = (mq.size() != 0);
    exp_req = !rd && ((mq.size() + int'(m_resp)) < DEPTH);
    check_eq("imem_req", bus_if.imem_req, exp_req);
    check_eq("imem_addr", bus_if.imem_addr, m_fpc);
    check_eq("instr_valid", bus_if.instr_valid, head_v);
    if (head_v) begin
      check_eq("instr_pc", bus_if.instr_pc, mq[0]);
      check_eq("instr", bus_if.instr, mq[0] ^ K);
    end
    check_eq("perf_fetched", bus_if.perf_fetched, PERF_ON ? m_fetched : 32'd0);
    check_eq("perf_stall", bus_if.perf_stall, PERF_ON ? m_stall : 32'd0);

    acc_dut  = bus_if.imem_req & mrdy;
    addr_dut = bus_if.imem_addr;

    if (head_v && !drdy) m_stall++;
    if (rd) begin
      mq.delete();
      m_fpc  = rpc & ~32'h3;
      m_resp = 1'b0;
    end else begin
      if (head_v && drdy) void'(mq.pop_front());
      if (m_resp) begin
        mq.push_back(m_resp_pc);
        m_fetched++;
      end
      if (exp_req && mrdy) begin
        m_resp    = 1'b1;
        m_resp_pc = m_fpc;
        m_fpc     = m_fpc + 32'd4;
      end else begin
        m_resp = 1'b0;
      end
    end

    @(posedge clk);
    mem_pend      = acc_dut;
    mem_pend_addr = addr_dut;
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] stall_base;
    logic [31:0] head_pc;
    logic [31:0] fetched_base;
    bit          found;
    bit          rd;
    logic [31:0] rpc;

    bus_if.redirect_valid = 1'b0;
    bus_if.redirect_pc    = '0;
    bus_if.imem_ready     = 1'b0;
    bus_if.imem_rvalid    = 1'b0;
    bus_if.imem_rdata     = '0;
    bus_if.instr_ready    = 1'b0;
    mem_pend              = 1'b0;
    mem_pend_addr         = '0;
    model_reset();
    @(negedge clk);
    do_reset(1'b0);

    // Streaming from reset: first head in C2, then one per cycle.
    step(1'b0, '0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1);
    check_eq("c2_valid", bus_if.instr_valid, 32'd1);
    check_eq("c2_pc", bus_if.instr_pc, 32'h100);
    step(1'b0, '0, 1'b1, 1'b1);
    check_eq("c3_pc", bus_if.instr_pc, 32'h104);
    repeat (6) step(1'b0, '0, 1'b1, 1'b1);

    // Decode stall for 10 cycles: queue fills, requests stop, head holds.
    stall_base = m_stall;
    head_pc    = mq[0];
    repeat (10) step(1'b0, '0, 1'b1, 1'b0);
    check_eq("full_req", bus_if.imem_req, 32'd0);
    check_eq("full_head", bus_if.instr_pc, head_pc);
    check_eq("full_stall", bus_if.perf_stall, PERF_ON ? stall_base + 32'd10 : 32'd0);
    repeat (8) step(1'b0, '0, 1'b1, 1'b1);

    // Memory back-pressure.
    repeat (3) step(1'b0, '0, 1'b0, 1'b1);
    repeat (4) step(1'b0, '0, 1'b1, 1'b1);

    // Mid-stream reset with a stale response after release, then build
    // 3 queued + 1 in flight and redirect with a response and pop pending.
    do_reset(1'b1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (mq.size() == 3 && m_resp) found = 1'b1;
      else step(1'b0, '0, 1'b1, 1'b0);
    end
    check_eq("redir_setup", found, 32'd1);
    fetched_base = m_fetched;
    step(1'b1, 32'h0000_2002, 1'b1, 1'b1);
    check_eq("redir_r1_valid", bus_if.instr_valid, 32'd0);
    check_eq("redir_no_push", bus_if.perf_fetched, PERF_ON ? fetched_base : 32'd0);
    step(1'b0, '0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1);
    check_eq("redir_r3_valid", bus_if.instr_valid, 32'd1);
    check_eq("redir_r3_pc", bus_if.instr_pc, 32'h2000);
    repeat (4) step(1'b0, '0, 1'b1, 1'b1);

    // Address wrap.
    step(1'b1, 32'hFFFF_FFFE, 1'b1, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1);
    check_eq("wrap_pc0", bus_if.instr_pc, 32'hFFFF_FFFC);
    step(1'b0, '0, 1'b1, 1'b1);
    check_eq("wrap_pc1", bus_if.instr_pc, 32'h0000_0000);
    step(1'b0, '0, 1'b1, 1'b1);
    check_eq("wrap_pc2", bus_if.instr_pc, 32'h0000_0004);

    // Randomized traffic with occasional redirects and resets.
    for (int i = 0; i < 800; i++) begin
      if (i % 250 == 249) begin
        do_reset($urandom_range(0, 1) == 1);
      end else begin
        rd  = ($urandom_range(0, 19) == 0);
        rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                          : 32'($urandom);
        step(rd, rpc, $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 6);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
